// File: rtl/shift_rows_serial.sv
// rtl/shift_rows_serial.sv - byte-serial AES ShiftRows with two-bank ping-pong buffer
module shift_rows_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inbyte,
  input  logic             enable,
  output logic [WIDTH-1:0] outbyte,
  output logic             ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Both banks in one array, addressed as {bank, byte index}
  logic [WIDTH-1:0] mem [0:31];

  logic [3:0] wcnt;
  logic       wbank;
  logic [3:0] rcnt;
  logic       rbank;
  logic [1:0] full;
  state_t     state;

  logic             wr_last;
  logic             other_ready;
  logic [3:0]       src_idx;
  logic [WIDTH-1:0] rd_data;

  // Byte 15 of a block is being captured on this edge
  assign wr_last = enable && (wcnt == 4'd15);

  // Output slot {c,r} takes the input byte from column (c+r) mod 4, row r
  assign src_idx = {rcnt[3:2] + rcnt[1:0], rcnt[1:0]};
  assign rd_data = mem[{rbank, src_idx}];

  // The bank not being drained is full now, or completes on this very edge
  assign other_ready = full[~rbank] || (wr_last && (wbank != rbank));

  // Bank storage; contents are never cleared, only overwritten
  always_ff @(posedge clock) begin
    if (enable) begin
      mem[{wbank, wcnt}] <= inbyte;
    end
  end

  // Write-side counter and bank select
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt  <= 4'd0;
      wbank <= 1'b0;
    end else if (enable) begin
      wcnt <= wcnt + 4'd1;
      if (wcnt == 4'd15) begin
        wbank <= ~wbank;
      end
    end
  end

  // Read FSM with bank-full flags; IDLE emits byte 0 on the edge it sees a
  // full bank so the first output lands one edge after the last capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rcnt    <= 4'd0;
      rbank   <= 1'b0;
      full    <= 2'b00;
      outbyte <= '0;
      ready   <= 1'b0;
    end else begin
      if (wr_last) begin
        full[wbank] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            outbyte <= rd_data;
            ready   <= 1'b1;
            rcnt    <= 4'd1;
            state   <= DRAIN;
          end else begin
            ready <= 1'b0;
          end
        end
        DRAIN: begin
          outbyte <= rd_data;
          ready   <= 1'b1;
          if (rcnt == 4'd15) begin
            full[rbank] <= 1'b0;
            rbank       <= ~rbank;
            rcnt        <= 4'd0;
            if (!other_ready) begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_serial.sv
// tb/tb_shift_rows_serial.sv - scoreboard bench for shift_rows_serial
module tb_shift_rows_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] inbyte = 8'h00;
  logic [7:0] outbyte;
  logic       ready;

  shift_rows_serial #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .inbyte  (inbyte),
    .enable  (enable),
    .outbyte (outbyte),
    .ready   (ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] v;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Hand-derived ShiftRows output order (FIPS-197 column-major)
  int order [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  // Monitor: pop and compare every presented byte, flag missing or extra ones
  always @(negedge clock) begin
    if (!reset) begin
      if (ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_ready: got outbyte=%02h at cycle %0d, expected no output", outbyte, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (outbyte !== mon_e.v || cyc != mon_e.c) begin
            n_fail++;
            $display("FAIL out_byte: got %02h at cycle %0d, expected %02h at cycle %0d",
                     outbyte, cyc, mon_e.v, mon_e.c);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_byte: ready low at cycle %0d, expected %02h at cycle %0d",
                 cyc, mon_e.v, mon_e.c);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    inbyte = b;
    enable = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b0;
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sends base..base+15; after the last capture at edge N, byte k is due at edge N+1+k
  task automatic send_block(input logic [7:0] base, input int g1_pos, input int g1_len,
                            input int g2_pos, input int g2_len);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      send_byte(base + 8'(i));
      if (i == 15) begin
        for (int k = 0; k < 16; k++) begin
          e.v = base + 8'(order[k]);
          e.c = cyc + 1 + k;
          exp_q.push_back(e);
        end
      end
      if (i == g1_pos) idle(g1_len);
      if (i == g2_pos) idle(g2_len);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clock);
      t++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asserts reset between edges and checks the outputs clear asynchronously
  task automatic mid_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_outbyte"}, 32'(outbyte), 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_outbyte", 32'(outbyte), 32'd0);
    reset = 1'b0;
    idle(2);

    // FIPS-197 order
    send_block(8'h00, -1, 0, -1, 0);
    wait_drain();
    idle(3);

    // Four back-to-back blocks: 64 contiguous outputs
    send_block(8'h00, -1, 0, -1, 0);
    send_block(8'h10, -1, 0, -1, 0);
    send_block(8'h20, -1, 0, -1, 0);
    send_block(8'h30, -1, 0, -1, 0);
    wait_drain();
    idle(3);

    // Enable gaps after bytes 4 and 11
    send_block(8'h00, 4, 3, 11, 3);
    wait_drain();
    idle(3);

    // Reset mid-input, then a clean block
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
    mid_reset("rst_input");
    send_block(8'h80, -1, 0, -1, 0);
    wait_drain();
    idle(3);

    // Reset at output byte 6, then next block from bank 0
    send_block(8'h50, -1, 0, -1, 0);
    repeat (7) @(posedge clock);
    #1;
    check("rst_drain_pending", 32'(exp_q.size()), 32'd10);
    mid_reset("rst_drain");
    send_block(8'h60, -1, 0, -1, 0);
    wait_drain();
    idle(3);

    // Second block fills on the first block's last output edge, then a gapped third
    send_block(8'hA0, -1, 0, -1, 0);
    send_block(8'hB0, -1, 0, -1, 0);
    idle(5);
    send_block(8'hC0, 2, 4, -1, 0);
    wait_drain();

    idle(20);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
